// File: rtl/ic7483_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder ic_7483_seq.
package ic7483_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ic_7483_seq_chunk_adder.sv
// Combinational CHUNK-bit ripple adder slice; c_msb is the carry into the top bit.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/ic_7483_seq.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, start/done handshake.
// Optional subtract port enabled by defining CHUNK_ADD_SUB_EN.
//
// state | meaning
// IDLE  | ready, waiting for start
// RUN   | one chunk added per clock
// DONE  | one-cycle result-valid pulse
module ic_7483_seq
  import ic7483_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
`ifdef CHUNK_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              cout_q, ovf_q;

  logic [WIDTH-1:0]  b_in;
  logic              carry_in;
  logic              accept, last;
  logic [31:0]       base;
  logic [CHUNK-1:0]  slice_s;
  logic              slice_c, slice_cmsb;

`ifdef CHUNK_ADD_SUB_EN
  // Subtract as A + ~B + 1; inverting at capture keeps the RUN datapath add-only.
  assign b_in     = sub ? ~B : B;
  assign carry_in = sub | C0;
`else
  assign b_in     = B;
  assign carry_in = C0;
`endif

  assign accept = (state_q == IDLE) && start;
  assign last   = (idx_q == IDX_LAST);
  assign base   = 32'(idx_q) * CHUNK;

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a     (a_q[base +: CHUNK]),
    .b     (b_q[base +: CHUNK]),
    .cin   (carry_q),
    .s     (slice_s),
    .cout  (slice_c),
    .c_msb (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= b_in;
      carry_q <= carry_in;
    end else if (state_q == RUN) begin
      sum_q[base +: CHUNK] <= slice_s;
      carry_q              <= slice_c;
      if (last) begin
        cout_q <= slice_c;
        ovf_q  <= slice_c ^ slice_cmsb;
      end
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign Cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_ic_7483_seq.sv
// Directed bench for ic_7483_seq at CHUNK=4, 16 and 1 (WIDTH=16).
module tb_ic_7483_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st4 = 1'b0, st16 = 1'b0, st1 = 1'b0;
  logic [15:0] a_r = '0, b_r = '0;
  logic        c0_r = 1'b0;
  logic        sub_r = 1'b0;

  logic        rdy4, bsy4, dn4, co4, ov4;
  logic        rdy16, bsy16, dn16, co16, ov16;
  logic        rdy1, bsy1, dn1, co1, ov1;
  logic [15:0] s4, s16, s1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ic_7483_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(st4), .A(a_r), .B(b_r), .C0(c0_r),
`ifdef CHUNK_ADD_SUB_EN
    .sub(sub_r),
`endif
    .ready(rdy4), .busy(bsy4), .done(dn4), .sum(s4), .Cout(co4), .ovf(ov4));

  ic_7483_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .A(a_r), .B(b_r), .C0(c0_r),
`ifdef CHUNK_ADD_SUB_EN
    .sub(sub_r),
`endif
    .ready(rdy16), .busy(bsy16), .done(dn16), .sum(s16), .Cout(co16), .ovf(ov16));

  ic_7483_seq #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a_r), .B(b_r), .C0(c0_r),
`ifdef CHUNK_ADD_SUB_EN
    .sub(sub_r),
`endif
    .ready(rdy1), .busy(bsy1), .done(dn1), .sum(s1), .Cout(co1), .ovf(ov1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 -> CHUNK=4, 1 -> CHUNK=16, 2 -> CHUNK=1; lat is NCHUNK of that instance.
  task automatic run_op(input int which, input logic [15:0] a, input logic [15:0] b,
                        input logic c0, input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo, input int lat, input string tag);
    logic d, co, ov;
    logic [15:0] s;
    @(negedge clk);
    a_r = a; b_r = b; c0_r = c0; sub_r = sb;
    case (which)
      0: st4 = 1'b1;
      1: st16 = 1'b1;
      default: st1 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    st4 = 1'b0; st16 = 1'b0; st1 = 1'b0;
    for (int e = 1; e <= lat + 1; e++) begin
      @(posedge clk);
      @(negedge clk);
      case (which)
        0:       begin d = dn4;  s = s4;  co = co4;  ov = ov4;  end
        1:       begin d = dn16; s = s16; co = co16; ov = ov16; end
        default: begin d = dn1;  s = s1;  co = co1;  ov = ov1;  end
      endcase
      check({tag, "_done_e", $sformatf("%0d", e)}, 32'(d), 32'(e == lat));
      if (e == lat) begin
        check({tag, "_sum"}, 32'(s), 32'(es));
        check({tag, "_cout"}, 32'(co), 32'(ec));
        check({tag, "_ovf"}, 32'(ov), 32'(eo));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(rdy4), 32'd1);
    check("rst_busy", 32'(bsy4), 32'd0);
    check("rst_done", 32'(dn4), 32'd0);
    check("rst_sum", 32'(s4), 32'd0);
    check("rst_cout", 32'(co4), 32'd0);
    check("rst_ovf", 32'(ov4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4, "add_basic");
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "add_wrap");
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "add_ovf");
    run_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "carry_chain");
    run_op(0, 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 4, "carry_mid");

    // start held high with operands changing every cycle; second op accepted at edge 6
    @(negedge clk);
    a_r = 16'h1111; b_r = 16'h2222; c0_r = 1'b0; st4 = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold_done_e%0d", e), 32'(dn4), 32'((e == 4) || (e == 10)));
      if (e == 4)  check("hold_sum1", 32'(s4), 32'h3333);
      if (e == 10) check("hold_sum2", 32'(s4), 32'h0666);
      if (e == 5)  check("hold_ready_e5", 32'(rdy4), 32'd1);
      a_r = 16'(e + 1) * 16'h0101;
      b_r = 16'(e + 1) * 16'h0010;
    end
    st4 = 1'b0;
    repeat (2) @(negedge clk);

    // reset during RUN, after two chunks have been written
    a_r = 16'hFFFF; b_r = 16'h0001; c0_r = 1'b0; st4 = 1'b1;
    @(posedge clk);
    #1 st4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(bsy4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_sum", 32'(s4), 32'd0);
    check("midrst_busy", 32'(bsy4), 32'd0);
    check("midrst_ready", 32'(rdy4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      check($sformatf("midrst_nodone_%0d", e), 32'(dn4), 32'd0);
    end
    run_op(0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 4, "after_rst");

    run_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1, "c16_basic");
    run_op(2, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 16, "c1_basic");
    run_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16, "c1_ovf");

`ifdef CHUNK_ADD_SUB_EN
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, "sub_neg");
    run_op(0, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 4, "sub_pos");
    run_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, "c16_sub");
    run_op(2, 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 16, "c1_sub");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
